// File: rtl/xyz_pkg.sv
// Shared definitions for the xyz sequence monitor: code constants,
// code-to-index decode table and FSM state encoding.
package xyz_pkg;

  // Legal codes in sequence order
  localparam logic [2:0] CODE_0 = 3'b000;
  localparam logic [2:0] CODE_1 = 3'b001;
  localparam logic [2:0] CODE_2 = 3'b010;
  localparam logic [2:0] CODE_3 = 3'b100;

  // Decode table indexed by code, entries are {valid, idx[1:0]}
  localparam logic [2:0] XYZ_DEC_TBL [8] = '{
    3'b100,  // 000 -> idx0
    3'b101,  // 001 -> idx1
    3'b110,  // 010 -> idx2
    3'b000,  // 011 invalid
    3'b111,  // 100 -> idx3
    3'b000,  // 101 invalid
    3'b000,  // 110 invalid
    3'b000   // 111 invalid
  };

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } xyz_state_e;

endpackage

// File: rtl/xyz_decode.sv
// Combinational decode of a 3-bit xyz code into {valid, idx}.
module xyz_decode
  import xyz_pkg::*;
(
  input  logic [2:0] i_code,
  output logic       o_valid,
  output logic [1:0] o_idx
);

  logic [2:0] w_entry;

  // Table lookup; invalid codes carry valid=0 so they never match
  always_comb begin
    w_entry = XYZ_DEC_TBL[i_code];
    o_valid = w_entry[2];
    o_idx   = w_entry[1:0];
  end

endmodule

// File: rtl/xyz_seq_monitor.sv
// Monitors the 000 -> 001 -> 010 -> 100 code sequence from an upstream
// sequencer, locks after LOCK_CNT good cycles and drops lock after
// ERR_LIMIT consecutive mismatches. Optional cycle counter output is
// enabled by defining XYZ_MON_CYCLE_CNT_EN.
module xyz_seq_monitor
  import xyz_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       xyz,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic             cycle_done,
`ifdef XYZ_MON_CYCLE_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
`endif
  output logic [1:0]       exp_idx
);

  localparam logic [3:0] LOCK_CNT_V  = 4'(LOCK_CNT);
  localparam logic [3:0] ERR_LIMIT_V = 4'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  xyz_state_e       r_state, w_state_d;
  logic [1:0]       r_exp_idx, w_exp_idx_d;
  logic [3:0]       r_good, w_good_d;
  logic [3:0]       r_miss, w_miss_d;
  logic             r_locked;
  logic             r_err_pulse, w_err_pulse_d;
  logic             r_cycle_done, w_cycle_done_d;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_valid;
  logic [1:0]       w_idx;
  logic             w_match;

  xyz_decode u_decode (
    .i_code  (xyz),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_match = w_valid && (w_idx == r_exp_idx);

  // Next-state logic; with en low everything holds and pulses stay low
  always_comb begin
    w_state_d      = r_state;
    w_exp_idx_d    = r_exp_idx;
    w_good_d       = r_good;
    w_miss_d       = r_miss;
    w_err_pulse_d  = 1'b0;
    w_cycle_done_d = 1'b0;
    if (en) begin
      unique case (r_state)
        ST_HUNT: begin
          if (xyz == CODE_0) begin
            w_state_d   = ST_TRACK;
            w_exp_idx_d = 2'd1;
            w_good_d    = 4'd0;
          end
        end
        ST_TRACK: begin
          if (w_match) begin
            w_exp_idx_d = r_exp_idx + 2'd1;
            if (w_idx == 2'd3) begin
              if (r_good + 4'd1 == LOCK_CNT_V) begin
                w_state_d = ST_LOCKED;
                w_good_d  = 4'd0;
                w_miss_d  = 4'd0;
              end else begin
                w_good_d = r_good + 4'd1;
              end
            end
          end else begin
            w_err_pulse_d = 1'b1;
            w_good_d      = 4'd0;
            // A fresh 000 restarts tracking rather than falling back to hunting
            if (xyz == CODE_0) begin
              w_exp_idx_d = 2'd1;
            end else begin
              w_state_d   = ST_HUNT;
              w_exp_idx_d = 2'd0;
            end
          end
        end
        ST_LOCKED: begin
          // Flywheel: keep advancing the expectation even on a miss
          w_exp_idx_d = r_exp_idx + 2'd1;
          if (w_match) begin
            w_miss_d       = 4'd0;
            w_cycle_done_d = (w_idx == 2'd3);
          end else begin
            w_err_pulse_d = 1'b1;
            if (r_miss + 4'd1 == ERR_LIMIT_V) begin
              w_state_d   = ST_HUNT;
              w_miss_d    = 4'd0;
              w_exp_idx_d = 2'd0;
            end else begin
              w_miss_d = r_miss + 4'd1;
            end
          end
        end
        default: begin
          w_state_d   = ST_HUNT;
          w_exp_idx_d = 2'd0;
          w_good_d    = 4'd0;
          w_miss_d    = 4'd0;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_HUNT;
      r_exp_idx    <= 2'd0;
      r_good       <= 4'd0;
      r_miss       <= 4'd0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_exp_idx    <= w_exp_idx_d;
      r_good       <= w_good_d;
      r_miss       <= w_miss_d;
      r_locked     <= (w_state_d == ST_LOCKED);
      r_err_pulse  <= w_err_pulse_d;
      r_cycle_done <= w_cycle_done_d;
    end
  end

  // Saturating error counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
    end else if (w_err_pulse_d && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

`ifdef XYZ_MON_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  // Wrapping count of completed locked cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
    end else if (w_cycle_done_d) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

  assign locked     = r_locked;
  assign err_pulse  = r_err_pulse;
  assign err_cnt    = r_err_cnt;
  assign cycle_done = r_cycle_done;
  assign exp_idx    = r_exp_idx;

endmodule

// File: doc/xyz_seq_monitor.md
XYZ_SEQ_MONITOR -- requirements
Module: xyz_seq_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of err_cnt and cycle_cnt.
REQ-002 SHALL have parameter LOCK_CNT, default 2, number of consecutive good full cycles needed to lock (1..15).
REQ-003 SHALL have parameter ERR_LIMIT, default 3, number of consecutive mismatches in LOCKED that drop lock (1..15).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, xyz sample valid this cycle.
REQ-007 SHALL have port xyz, input, 3, code from the upstream xyz sequencer.
REQ-008 SHALL have port locked, output, 1, high while in LOCKED.
REQ-009 SHALL have port err_pulse, output, 1, one-cycle pulse per mismatched sample in TRACK or LOCKED.
REQ-010 SHALL have port err_cnt, output, CNT_W, saturating count of err_pulse events.
REQ-011 SHALL have port cycle_done, output, 1, one-cycle pulse when code 100 is accepted in LOCKED.
REQ-012 SHALL have port exp_idx, output, 2, index of the next expected code.

Function
REQ-013 SHALL use code map: idx0=000, idx1=001, idx2=010, idx3=100; any other code is invalid and never matches.
REQ-014 SHALL sample xyz only when en=1; with en=0 all state, counters and outputs hold and pulses are 0.
REQ-015 SHALL register all outputs; the response to a sample appears one cycle after the sampling edge.
REQ-016 SHALL implement FSM states HUNT, TRACK and LOCKED.
REQ-017 HUNT: xyz=000 -> TRACK, exp_idx=1, good=0; any other code stays in HUNT with no err_pulse.
REQ-018 TRACK: match -> exp_idx+1 mod 4; acceptance of 100 increments good; good reaching LOCK_CNT -> LOCKED.
REQ-019 TRACK mismatch: err_pulse=1; if xyz=000 stay in TRACK with exp_idx=1 and good=0, else -> HUNT.
REQ-020 LOCKED match: exp_idx+1 mod 4, miss=0, cycle_done=1 when 100 accepted.
REQ-021 LOCKED mismatch: err_pulse=1, miss+1, exp_idx still advances (flywheel); miss reaching ERR_LIMIT -> HUNT with miss=0.
REQ-022 err_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-023 exp_idx SHALL wrap 3 -> 0.

Reset
REQ-024 With rst=0: state=HUNT, exp_idx=0, good=0, miss=0, locked=0, err_pulse=0, cycle_done=0, err_cnt=0, cycle_cnt=0.
REQ-025 Reset assertion mid-cycle SHALL take effect immediately and override any simultaneous sample.
REQ-026 After rst deasserts, the first sample on the next rising edge SHALL be evaluated from HUNT.

Configuration
REQ-027 With XYZ_MON_CYCLE_CNT_EN defined: output cycle_cnt [CNT_W-1:0] counts cycle_done pulses, wraps at 2^CNT_W.
REQ-028 Without XYZ_MON_CYCLE_CNT_EN: the cycle_cnt port and its register are absent; all other behaviour is unchanged.

Structure
REQ-029 Package xyz_pkg SHALL hold the four code constants, the code-to-index table and the FSM state enum.
REQ-030 Sub-module xyz_decode SHALL map a 3-bit code to {valid, idx[1:0]} combinationally.

Verification
REQ-031 Reset, en=1, xyz cycles 000,001,010,100 repeatedly -> locked=1 one cycle after the second 100 (LOCK_CNT=2); err_cnt=0.
REQ-032 Locked, inject 011 once then resume the correct sequence -> one err_pulse, err_cnt=1, locked stays 1.
REQ-033 Locked, three consecutive wrong codes (111) -> three err_pulses, locked=0 after the third, state HUNT.
REQ-034 en toggled 1/0 every cycle over a valid sequence -> lock occurs after 8 accepted samples; outputs hold in en=0 cycles.
REQ-035 CNT_W=2, 5 errors -> err_cnt reads 3 and holds.
REQ-036 rst pulsed low while locked with xyz=010 -> locked=0, exp_idx=0 immediately; with macro defined cycle_cnt=0.
